// File: rtl/regfile_write_port.sv
// Write side of the CPU register file: valid/ready write port with byte enables,
// one-hot address decode, a hardwired-zero entry 0 and a sequential clear sweep.
module regfile_write_port #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH/8-1:0]        wr_be,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                clr_done_q, clr_done_d;
  logic                wr_accept;
  logic [WIDTH-1:0]    be_mask;
  logic [NUM_REGS-1:1] wr_sel;
  logic [NUM_REGS-1:1] sweep_sel;

  assign wr_ready  = (state_q == IDLE);
  assign clr_busy  = (state_q == SWEEP);
  assign clr_done  = clr_done_q;
  assign wr_accept = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Entry 0 is constant zero, so the sweep starts at index 1.
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = ADDR_W'(1);
        end
      end
      SWEEP: begin
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d    = IDLE;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_be
    assign be_mask[8*gi +: 8] = {8{wr_be[gi]}};
  end

  assign regs_flat[WIDTH-1:0] = '0;

  // Addresses with no matching entry (0 or >= NUM_REGS) select nothing.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [WIDTH-1:0] reg_q, reg_d;

    assign wr_sel[gi]    = wr_accept && (wr_addr == ADDR_W'(gi));
    assign sweep_sel[gi] = (state_q == SWEEP) && (idx_q == ADDR_W'(gi));

    always_comb begin
      reg_d = reg_q;
      if (sweep_sel[gi]) begin
        reg_d = '0;
      end else if (wr_sel[gi]) begin
        reg_d = (reg_q & ~be_mask) | (wr_data & be_mask);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_flat[WIDTH*gi +: WIDTH] = reg_q;
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: directed scenarios plus randomized
// writes compared against an array-based reference model of the register file.
module tb_regfile_write_port;

  localparam int NUM_REGS = 32;
  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;

  logic                      clk;
  logic                      rst;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [WIDTH/8-1:0]        wr_be;
  logic                      clr_req;
  logic                      clr_busy;
  logic                      clr_done;
  logic [NUM_REGS*WIDTH-1:0] regs_flat;

  logic [WIDTH-1:0] exp_regs [NUM_REGS];
  int checks = 0;
  int errors = 0;

  regfile_write_port #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .regs_flat(regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] entry(input int i);
    return regs_flat[WIDTH*i +: WIDTH];
  endfunction

  // Reference: byte-merge into the addressed entry; entry 0 stays zero.
  function automatic void model_write(input int a, input logic [WIDTH-1:0] d,
                                      input logic [WIDTH/8-1:0] be);
    if (a == 0 || a >= NUM_REGS) return;
    for (int k = 0; k < WIDTH / 8; k++)
      if (be[k]) exp_regs[a][8*k +: 8] = d[8*k +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single write issued while the block is idle.
  task automatic do_write(input int a, input logic [WIDTH-1:0] d,
                          input logic [WIDTH/8-1:0] be);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(a);
    wr_data  = d;
    wr_be    = be;
    step();
    wr_valid = 1'b0;
    model_write(a, d, be);
    $display("write addr=%0d data=%h be=%b", a, d, be);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (entry(i) !== '0) begin
        errors++;
        $display("FAIL reset_entry%0d got %h expected 00000000", i, entry(i));
      end
    end
    checks++;
    if ({wr_ready, clr_busy, clr_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got ready/busy/done=%b expected 100",
               {wr_ready, clr_busy, clr_done});
    end
  endtask

  task automatic test_basic_write();
    do_write(5, 32'hDEADBEEF, 4'hF);
    do_write(31, 32'h12345678, 4'hF);
    checks++;
    if (entry(5) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_addr5 got %h expected deadbeef", entry(5));
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (entry(i) !== exp_regs[i]) begin
        errors++;
        $display("FAIL basic_entry%0d got %h expected %h", i, entry(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_reg0();
    wr_valid = 1'b1;
    wr_addr  = '0;
    wr_data  = 32'hFFFFFFFF;
    wr_be    = 4'hF;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_ready got %b expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    $display("write addr=0 data=ffffffff be=1111");
    checks++;
    if (entry(0) !== '0) begin
      errors++;
      $display("FAIL reg0_value got %h expected 00000000", entry(0));
    end
  endtask

  task automatic test_byte_enable();
    do_write(7, 32'hFFFFFFFF, 4'hF);
    do_write(7, 32'h11223344, 4'b0101);
    checks++;
    if (entry(7) !== 32'hFF22FF44 || exp_regs[7] !== 32'hFF22FF44) begin
      errors++;
      $display("FAIL byte_enable got %h expected ff22ff44", entry(7));
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cnt, done_cnt, done_at;
    do_write(1, 32'hA5A5A5A5, 4'hF);
    do_write(16, 32'h5A5A5A5A, 4'hF);
    do_write(31, 32'h0F0F0F0F, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    $display("clear sweep started");
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 40; k++) begin
      busy_cnt += int'(clr_busy);
      if (clr_done) begin done_cnt++; done_at = k; end
      checks++;
      if (wr_ready !== !clr_busy) begin
        errors++;
        $display("FAIL sweep_ready_k%0d got ready=%b busy=%b", k, wr_ready, clr_busy);
      end
      if (k == 15) begin
        // After 15 sweep edges only entries 1..15 have been reached.
        checks++;
        if (entry(16) !== 32'h5A5A5A5A) begin
          errors++;
          $display("FAIL sweep_entry16_mid got %h expected 5a5a5a5a", entry(16));
        end
        checks++;
        if (entry(1) !== '0 || entry(31) !== 32'h0F0F0F0F) begin
          errors++;
          $display("FAIL sweep_partial got e1=%h e31=%h expected 0/0f0f0f0f",
                   entry(1), entry(31));
        end
      end
      step();
    end
    checks++;
    if (busy_cnt != NUM_REGS - 1) begin
      errors++;
      $display("FAIL sweep_busy_cycles got %0d expected %0d", busy_cnt, NUM_REGS - 1);
    end
    checks++;
    if (done_cnt != 1 || done_at != NUM_REGS - 1) begin
      errors++;
      $display("FAIL sweep_done_pulse got count=%0d at=%0d expected 1 at %0d",
               done_cnt, done_at, NUM_REGS - 1);
    end
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (entry(i) !== '0) begin
        errors++;
        $display("FAIL sweep_entry%0d got %h expected 00000000", i, entry(i));
      end
    end
  endtask

  task automatic test_stall_write();
    bit seen;
    clr_req = 1'b1;
    step();
    clr_req  = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'hCAFEF00D;
    wr_be    = 4'hF;
    $display("stalled write addr=3 data=cafef00d during sweep");
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (clr_done) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_done_timeout got no clr_done expected pulse within 40 cycles");
    end
    checks++;
    if (wr_ready !== 1'b1 || entry(3) !== '0) begin
      errors++;
      $display("FAIL stall_pre_commit got ready=%b e3=%h expected 1/00000000",
               wr_ready, entry(3));
    end
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    model_write(3, 32'hCAFEF00D, 4'hF);
    checks++;
    if (entry(3) !== exp_regs[3]) begin
      errors++;
      $display("FAIL stall_commit got %h expected %h", entry(3), exp_regs[3]);
    end
  endtask

  task automatic test_clr_held();
    bit seen;
    clr_req = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h13579BDF;
    wr_be    = 4'hF;
    $display("clr_req held, pending write addr=9 data=13579bdf");
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (clr_done) seen = 1'b1;
      else step();
    end
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    checks++;
    if (!seen || clr_busy !== 1'b1 || entry(9) !== 32'h13579BDF) begin
      errors++;
      $display("FAIL held_restart got seen=%b busy=%b e9=%h expected 1/1/13579bdf",
               seen, clr_busy, entry(9));
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (clr_done) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen || entry(9) !== '0) begin
      errors++;
      $display("FAIL held_second_sweep got seen=%b e9=%h expected 1/00000000",
               seen, entry(9));
    end
    step();
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    do_write(20, 32'h89ABCDEF, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset asserted at sweep cycle 10");
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    checks++;
    if (wr_ready !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags got ready/busy/done=%b expected 100",
               {wr_ready, clr_busy, clr_done});
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      if (entry(i) !== '0) begin
        errors++;
        $display("FAIL abort_entry%0d got %h expected 00000000", i, entry(i));
      end
    end
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      done_cnt += int'(clr_done);
      step();
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses expected 0", done_cnt);
    end
  endtask

  task automatic test_random();
    int a;
    logic [WIDTH-1:0] d;
    logic [WIDTH/8-1:0] be;
    for (int n = 0; n < 150; n++) begin
      a  = int'($urandom_range(0, NUM_REGS - 1));
      d  = WIDTH'($urandom);
      be = (WIDTH/8)'($urandom);
      do_write(a, d, be);
      if ($urandom_range(0, 3) == 0) step();
      for (int i = 0; i < NUM_REGS; i++) begin
        checks++;
        if (entry(i) !== exp_regs[i]) begin
          errors++;
          $display("FAIL random_n%0d_entry%0d got %h expected %h",
                   n, i, entry(i), exp_regs[i]);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = '0;
    clr_req  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    test_reset();
    test_basic_write();
    test_reg0();
    test_byte_enable();
    test_clear_sweep();
    test_stall_write();
    test_clr_held();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
